// File: rtl/buffer_reader_pkg.sv
// Shared NoC definitions for the buffer reader.
// Holds the flit-type encoding, where the type field sits in a flit, the
// packet-framing FSM state encoding and a helper to pull the type out of a
// flit of any width.
package buffer_reader_pkg;

  // Type field occupies the two most significant bits of every flit:
  // flit[FLIT_SIZE-1 : FLIT_SIZE-2].
  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  // Type field of a flit, given only its top two bits (caller slices them
  // with [FLIT_SIZE-1 -: FLIT_TYPE_W] so this stays width-agnostic).
  function automatic flit_type_e flit_type(input logic [FLIT_TYPE_W-1:0] top_bits);
    return flit_type_e'(top_bits);
  endfunction

endpackage

// File: rtl/buffer_reader_flit_out_reg.sv
// flit_out_reg: one-entry output register with valid/ready handshake.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   data_i      flit to capture when load_i is high
//   load_i      capture data_i this edge (caller only loads when accept_o)
//   ready_i     downstream accepts flit_o this cycle
//   flit_o      registered flit
//   valid_o     flit_o holds a valid flit
//   accept_o    register can take a new flit this edge (empty or draining)
//   hs_o        handshake this cycle (valid_o && ready_i)
module flit_out_reg #(
  parameter int FLIT_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 load_i,
  input  logic                 ready_i,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 valid_o,
  output logic                 accept_o,
  output logic                 hs_o
);

  logic [FLIT_SIZE-1:0] flit_q, flit_d;
  logic                 vld_q, vld_d;

  assign accept_o = !vld_q || ready_i;
  assign hs_o     = vld_q && ready_i;

  // A load during a handshake replaces the flit in place: no bubble.
  // Without a load, a handshake empties the register; otherwise hold.
  always_comb begin
    flit_d = flit_q;
    vld_d  = vld_q;
    if (load_i) begin
      flit_d = data_i;
      vld_d  = 1'b1;
    end else if (hs_o) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      flit_q <= flit_d;
      vld_q  <= vld_d;
    end
  end

  assign flit_o  = flit_q;
  assign valid_o = vld_q;

endmodule

// File: rtl/buffer_reader.sv
// buffer_reader: drains a first-word-fall-through flit buffer into a
// registered valid/ready output, returns one credit per delivered flit,
// and checks packet framing on delivered flits.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   buf_data_i     head flit of upstream buffer (valid when !buf_empty_i)
//   buf_empty_i    upstream buffer empty
//   buf_read_o     pop request; the buffer pops on the same rising edge
//   flit_o         registered flit to downstream
//   valid_o        flit_o valid
//   ready_i        downstream accepts flit_o
//   credit_o       one-cycle pulse, the cycle after each handshake
//   pkt_cnt_o      completed packets, wraps
//   err_o          sticky framing error
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int FLIT_SIZE = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] buf_data_i,
  input  logic                 buf_empty_i,
  output logic                 buf_read_o,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 credit_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic                 err_o
);

  logic accept, hs;

  // Gated by rst so nothing is popped while in reset.
  assign buf_read_o = !rst && !buf_empty_i && accept;

  flit_out_reg #(.FLIT_SIZE(FLIT_SIZE)) u_out (
    .clk      (clk),
    .rst      (rst),
    .data_i   (buf_data_i),
    .load_i   (buf_read_o),
    .ready_i  (ready_i),
    .flit_o   (flit_o),
    .valid_o  (valid_o),
    .accept_o (accept),
    .hs_o     (hs)
  );

  // ---------------- packet framing FSM ----------------
  pkt_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 credit_q, credit_d;
  flit_type_e           ftype;

  assign ftype = flit_type(flit_o[FLIT_SIZE-1 -: FLIT_TYPE_W]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    credit_d = hs;
    if (hs) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (ftype)
            FT_HEAD:      state_d = ST_IN_PKT;
            FT_HEAD_TAIL: cnt_d   = cnt_q + 1'b1;
            default:      err_d   = 1'b1;       // BODY/TAIL with no open packet
          endcase
        end
        ST_IN_PKT: begin
          unique case (ftype)
            FT_BODY: ;
            FT_TAIL: begin
              state_d = ST_IDLE;
              cnt_d   = cnt_q + 1'b1;
            end
            FT_HEAD: err_d = 1'b1;               // new head inside a packet
            FT_HEAD_TAIL: begin                  // closes abruptly, still counted
              state_d = ST_IDLE;
              err_d   = 1'b1;
              cnt_d   = cnt_q + 1'b1;
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

  assign credit_o  = credit_q;
  assign pkt_cnt_o = cnt_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_buffer_reader.sv
module tb_buffer_reader;

  logic       clk;
  logic       rst;
  logic [7:0] buf_data_i;
  logic       buf_empty_i;
  logic       buf_read_o;
  logic [7:0] flit_o;
  logic       valid_o;
  logic       ready_i;
  logic       credit_o;
  logic [7:0] pkt_cnt_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       rd;

  buffer_reader #(.FLIT_SIZE(8), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .buf_data_i (buf_data_i),
    .buf_empty_i(buf_empty_i),
    .buf_read_o (buf_read_o),
    .flit_o     (flit_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .credit_o   (credit_o),
    .pkt_cnt_o  (pkt_cnt_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present the queue head as a FWFT buffer, then let logic settle.
  task automatic refresh();
    buf_empty_i = (q.size() == 0);
    buf_data_i  = (q.size() == 0) ? 8'h00 : q[0];
    #1;
  endtask

  // One clock: sample pop request before the edge, pop at the edge.
  task automatic cyc();
    #2;
    rd = buf_read_o;
    @(posedge clk);
    if (rd && q.size() > 0) void'(q.pop_front());
    #1;
    refresh();
  endtask

  initial begin
    int credits;
    rst = 1'b1; ready_i = 1'b0; rd = 1'b0;
    q = '{8'h01, 8'h45, 8'h89};
    @(posedge clk); #1; refresh();

    // reset state, buffer non-empty
    chk("rst_rd", buf_read_o, 0);
    cyc();
    chk("rst_valid", valid_o, 0);
    chk("rst_flit", flit_o, 0);
    chk("rst_credit", credit_o, 0);
    chk("rst_cnt", pkt_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rd2", buf_read_o, 0);
    chk("rst_nopop", q.size(), 3);

    // HEAD/BODY/TAIL streamed with ready high
    rst = 1'b0; ready_i = 1'b1; refresh();
    chk("s_rd0", buf_read_o, 1);
    cyc();
    chk("s_f1", flit_o, 8'h01); chk("s_v1", valid_o, 1); chk("s_c1", credit_o, 0);
    chk("s_rd1", buf_read_o, 1);
    cyc();
    chk("s_f2", flit_o, 8'h45); chk("s_c2", credit_o, 1); chk("s_rd2", buf_read_o, 1);
    cyc();
    chk("s_f3", flit_o, 8'h89); chk("s_c3", credit_o, 1); chk("s_rd3", buf_read_o, 0);
    cyc();
    chk("s_v4", valid_o, 0); chk("s_c4", credit_o, 1);
    chk("s_cnt", pkt_cnt_o, 1); chk("s_err", err_o, 0);
    cyc();
    chk("s_c5", credit_o, 0);

    // stall: C5 held four cycles with a second flit waiting
    ready_i = 1'b0; q.push_back(8'hC5); q.push_back(8'hC6); refresh();
    chk("st_rd0", buf_read_o, 1);
    cyc();
    chk("st_load", flit_o, 8'hC5);
    for (int i = 0; i < 4; i++) begin
      chk("st_flit", flit_o, 8'hC5);
      chk("st_valid", valid_o, 1);
      chk("st_rd", buf_read_o, 0);
      chk("st_credit", credit_o, 0);
      cyc();
    end
    ready_i = 1'b1; refresh();
    cyc();
    chk("st_rel_c", credit_o, 1); chk("st_rel_f", flit_o, 8'hC6);
    chk("st_cnt2", pkt_cnt_o, 2);
    ready_i = 1'b0; refresh();
    cyc();
    chk("st_hold_c", credit_o, 0); chk("st_hold_f", flit_o, 8'hC6);
    ready_i = 1'b1; refresh();
    cyc();
    chk("st_c6", credit_o, 1); chk("st_v6", valid_o, 0); chk("st_cnt3", pkt_cnt_o, 3);

    // empty buffer, ready toggling
    for (int i = 0; i < 4; i++) begin
      ready_i = i[0]; refresh();
      cyc();
      chk("e_rd", buf_read_o, 0); chk("e_valid", valid_o, 0); chk("e_credit", credit_o, 0);
    end

    // BODY in IDLE -> error, then HEAD_TAIL still counted
    ready_i = 1'b1; q.push_back(8'h40); q.push_back(8'hC0); refresh();
    cyc();
    chk("f_body", flit_o, 8'h40);
    cyc();
    chk("f_err", err_o, 1); chk("f_cnt", pkt_cnt_o, 3); chk("f_ht", flit_o, 8'hC0);
    cyc();
    chk("f_cnt2", pkt_cnt_o, 4); chk("f_err2", err_o, 1);

    // reset inside a packet with a flit held
    ready_i = 1'b0; q.push_back(8'h01); q.push_back(8'h45); refresh();
    cyc();
    ready_i = 1'b1; refresh();
    cyc();
    chk("r_held", flit_o, 8'h45); chk("r_v", valid_o, 1);
    rst = 1'b1; q.push_back(8'h89); refresh();
    chk("r_rd_in_rst", buf_read_o, 0);
    cyc();
    chk("r_valid", valid_o, 0); chk("r_flit", flit_o, 0); chk("r_credit", credit_o, 0);
    chk("r_cnt", pkt_cnt_o, 0); chk("r_err", err_o, 0);
    rst = 1'b0; refresh();
    chk("r_rd_after", buf_read_o, 1);
    cyc();
    chk("r_f89", flit_o, 8'h89); chk("r_c0", credit_o, 0);
    cyc();
    // TAIL in IDLE flags an error only if the FSM really went back to IDLE
    chk("r_idle_err", err_o, 1); chk("r_idle_cnt", pkt_cnt_o, 0); chk("r_c1", credit_o, 1);

    // 256 HEAD_TAIL flits wrap the counter
    rst = 1'b1; refresh(); cyc(); rst = 1'b0;
    for (int i = 0; i < 256; i++) q.push_back(8'hC0 | (i[7:0] & 8'h3F));
    refresh();
    credits = 0;
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (credit_o) begin
        credits++;
        if (credits == 255) chk("w_cnt255", pkt_cnt_o, 8'hFF);
      end
      if (q.size() == 0 && !valid_o && !credit_o) break;
    end
    chk("w_drained", (q.size() == 0 && !valid_o), 1);
    chk("w_credits", credits, 256);
    chk("w_cnt0", pkt_cnt_o, 0);
    chk("w_err", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
